// File: rtl/unit_arbiter.sv
// unit_arbiter: round-robin arbiter that time-shares one compute unit among N requesters,
// with rising-edge completion detection and a RUN-cycle timeout.
module unit_arbiter #(
  parameter int N = 4,
  parameter int W = 32,
  parameter int TMO = 1023
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] ARGin,
  output logic [N-1:0]   ACK,
  output logic [W-1:0]   RESout,
  output logic           ERR,
  output logic           BUSY,
  output logic [W-1:0]   U_ARG,
  output logic           U_RST,
  input  logic           U_RES,
  input  logic [W-1:0]   U_DATA
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;
  logic [1:0]    state;
  logic [PW-1:0] ptr, g, win;
  logic [TW-1:0] timer;
  logic          res_old, just_done, hit, rise;
  logic [N-1:0]  elig;
  // the requester just served sits out the first IDLE cycle so others get a turn
  always_comb begin
    elig = REQ;
    if (just_done) elig[ptr] = 1'b0;
    win = ptr;
    hit = 1'b0;
    for (int i = 1; i <= N; i++)
      if (!hit && elig[(int'(ptr) + i) % N]) begin
        win = PW'((int'(ptr) + i) % N);
        hit = 1'b1;
      end
  end
  assign rise = U_RES & ~res_old;
  always_ff @(posedge CLK)
    if (!RST) begin
      state     <= IDLE;
      ACK       <= '0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
      RESout    <= '0;
      U_ARG     <= '0;
      U_RST     <= 1'b0;
      timer     <= '0;
      ptr       <= PW'(N - 1);
      g         <= '0;
      res_old   <= 1'b1;
      just_done <= 1'b0;
    end else begin
      res_old   <= U_RES;
      just_done <= 1'b0;
      case (state)
        IDLE: if (hit) begin
          g     <= win;
          U_ARG <= ARGin[win*W +: W];
          BUSY  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          U_RST <= 1'b1;
          state <= RUN;
        end
        RUN: if (rise || timer == TW'(TMO)) begin
          RESout <= rise ? U_DATA : '0;
          ERR    <= ~rise;
          ACK    <= N'(1) << g;
          state  <= DONE;
        end else timer <= timer + 1'b1;
        DONE: begin
          ACK       <= '0;
          ERR       <= 1'b0;
          U_RST     <= 1'b0;
          BUSY      <= 1'b0;
          ptr       <= g;
          timer     <= '0;
          just_done <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
endmodule

// File: doc/unit_arbiter.md
UNIT_ARBITER -- requirements
Module: unit_arbiter

Interface
REQ-001 Parameters SHALL be: N, 4, number of requesters; W, 32, argument/result width; TMO, 1023, timeout limit in RUN cycles (timer width SHALL be clog2(TMO+1)).
REQ-002 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  reset; synchronous and active-low.
REQ-004 REQ  in  N  request level per requester, held until ACK.
REQ-005 ARGin  in  N*W  argument of requester i at bits [i*W+W-1 : i*W].
REQ-006 ACK  out  N  one-cycle completion pulse to the granted requester.
REQ-007 RESout  out  W  result data; valid when any ACK bit is 1, held until the next completion.
REQ-008 ERR  out  1  timeout flag; pulses together with ACK.
REQ-009 BUSY  out  1  high in LOAD, RUN and DONE.
REQ-010 U_ARG  out  W  argument to the shared unit.
REQ-011 U_RST  out  1  active-low hold of the shared unit; 0 = unit idle, 1 = compute.
REQ-012 U_RES  in  1  unit done level; completion is its rising edge.
REQ-013 U_DATA  in  W  unit result; sampled on the cycle the U_RES rising edge is detected.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, RUN and DONE; all outputs SHALL be registered.
REQ-015 IDLE: if any eligible REQ bit is 1, the block SHALL select winner g by round-robin, searching from ptr+1 upward modulo N, and latch g.
- Same cycle: U_ARG <= ARGin slice g.
- Next state: LOAD.
REQ-016 LOAD (exactly one cycle): U_RST SHALL remain 0; on exit U_RST <= 1 and the state SHALL go to RUN.
REQ-017 Edge detection: register res_old SHALL sample U_RES every cycle; a rising edge is U_RES==1 and res_old==0.
REQ-018 Edges SHALL be acted on only in RUN.
REQ-019 A U_RES level already high on entry to RUN SHALL NOT count; U_RES must fall and rise again.
REQ-020 RUN: the timer SHALL increment each cycle from 0.
- On a rising edge: RESout <= U_DATA, ERR <= 0, go to DONE.
- Else, when the timer equals TMO: RESout <= 0, ERR <= 1, go to DONE.
- If both occur in the same cycle, the edge SHALL win.
REQ-021 DONE (one cycle):
- ACK[g] SHALL be 1 (other ACK bits 0); ERR as set in RUN.
- Updates: U_RST <= 0, ptr <= g, timer <= 0.
- Next state: IDLE.
REQ-022 Eligibility: in the IDLE cycle immediately after DONE, requester g SHALL be masked; at all other times every REQ bit is eligible.
REQ-023 Deassertion of REQ[g] during LOAD or RUN SHALL NOT abort the operation; ACK[g] SHALL still be issued.
REQ-024 Changes to ARGin after grant SHALL NOT affect U_ARG until the next grant.
REQ-025 Latency: with REQ sampled in IDLE at edge k, U_RST SHALL be 1 from edge k+2; ACK SHALL appear one cycle after the detecting edge.
REQ-026 A new grant SHALL occur no earlier than the IDLE cycle following DONE, so at most one operation is in flight.

Reset
REQ-027 While RST==0 at a rising CLK edge, the block SHALL load these values:
- state IDLE;
- ACK = 0, ERR = 0, BUSY = 0;
- RESout = 0, U_ARG = 0, U_RST = 0;
- timer = 0;
- ptr = N-1, so requester 0 has first priority;
- res_old = 1.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no ACK issued and U_RST driven to 0 on the same edge.

Verification
REQ-029 Single request: REQ=0001, ARGin[0]=5; unit raises U_RES 4 cycles after U_RST goes 1 with U_DATA=120 -> ACK=0001 one cycle after the edge, RESout=120, ERR=0.
REQ-030 Round-robin: REQ=1111 held with each requester dropping its bit after ACK -> grant order 0,1,2,3; a second pass with REQ=0101 -> order 0,2.
REQ-031 Stale done: U_RES held 1 across grant, falls, then rises 3 cycles later -> exactly one ACK, issued after the second rise only.
REQ-032 Timeout: TMO=8, U_RES held 0 -> ACK and ERR both 1 in the DONE cycle 9 cycles after U_RST rises, RESout=0, U_RST=0 the following cycle.
REQ-033 Reset mid-RUN: RST=0 for one cycle during RUN -> no ACK, U_RST=0, BUSY=0; after release, REQ=0010 granted first ahead of a simultaneous REQ bit 3, since ptr=N-1.
REQ-034 Simultaneous edge and timeout in the same RUN cycle -> ERR=0, RESout=U_DATA.
